ram_large_arbiter: RTL and testbench
====================================

Name: ram_large_arbiter

Overview:
- Two-requester round-robin arbiter and access sequencer for the 16K x 16 banked single-port synchronous RAM (4 banks selected by addr[13:12]).
- Port 0 is the instruction-fetch side and port 1 is the load/store side; both share one RAM.
- Converts req/gnt transactions into the RAM's cs/we/oe/addr timing.
- Owns the controller side of the bidirectional data bus and returns registered read data with a valid pulse.

Parameters:
ADDR_WIDTH, 14, RAM word address width; bank field is the top 2 bits, passed through unchanged.
DATA_WIDTH, 16, RAM word width.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
p0_req  input  1  port 0 request; held with operands until p0_gnt seen.
p0_we  input  1  port 0: 1 = write, 0 = read.
p0_addr  input  ADDR_WIDTH  port 0 word address.
p0_wdata  input  DATA_WIDTH  port 0 write data.
p0_gnt  output  1  one-cycle pulse; request accepted, operands latched.
p0_rvalid  output  1  one-cycle pulse; p0_rdata valid.
p0_rdata  output  DATA_WIDTH  port 0 read data, held until the next port 0 read completes.
p1_*  (same seven signals for port 1).
ram_addr  output  ADDR_WIDTH  RAM address.
ram_data  inout  DATA_WIDTH  RAM data bus.
ram_cs  output  1  RAM chip select.
ram_we  output  1  RAM write enable.
ram_oe  output  1  RAM output enable.
busy  output  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, WRITE, RD_ADDR, RD_DATA. All outputs are registered or decoded from state and latched registers only; no combinational path from p*_req.
- Reset (async, rst_n=0) forces:
  - state = IDLE.
  - ram_cs/ram_we/ram_oe = 0; ram_addr = 0.
  - ram_data = high-Z.
  - All gnt/rvalid = 0; all rdata = 0.
  - last_grant = 1, so port 0 wins the first contention.
  - Any in-flight operation is abandoned with no rvalid.
- IDLE, at edge E0 with any req high:
  - Select the winner: a sole requester wins. If both request, the port != last_grant wins.
  - Latch winner's addr/we/wdata and the port id; set last_grant = winner.
  - Pulse the winner's gnt for the cycle after E0.
  - Go to WRITE if the winner's we = 1, else RD_ADDR.
- WRITE (one cycle):
  - ram_cs = 1, ram_we = 1, ram_oe = 0, ram_addr = latched addr.
  - ram_data driven with latched wdata. The RAM writes at E1.
  - Go to IDLE.
- RD_ADDR (one cycle):
  - ram_cs = 1, ram_we = 0, ram_oe = 0, ram_addr = latched addr. The RAM captures the word at E1.
  - Go to RD_DATA.
- RD_DATA (one cycle):
  - ram_cs = 1, ram_oe = 1, ram_we = 0, same addr. The RAM drives ram_data.
  - At E2 sample ram_data into the owning port's rdata and pulse its rvalid for the cycle after E2.
  - Go to IDLE.
- ram_data is driven by this block only in WRITE; it is high-Z in every other state (no contention with the RAM).
- Occupancy:
  - Write: 2 cycles from acceptance edge back to IDLE.
  - Read: 3 cycles.
  - Read latency: rvalid in the 2nd cycle after the gnt cycle.
- Requests are sampled only in IDLE. A req still high at the first IDLE edge after its gnt counts as a new request.
- A non-requesting port never receives gnt or rvalid. rdata of the other port is unchanged.
- Address wrap: none. The full 2^ADDR_WIDTH space is valid, and addr[13:12] reaches the RAM bank decoder unmodified.

Test Plan:
- Reset mid-read: assert rst_n=0 during RD_DATA -> immediately ram_cs=0, ram_data Z, busy=0. No rvalid follows, and rdata=0.
- Single write then read, port 0: write addr 0x0005 data 0xA5C3, then read 0x0005 -> ram_cs/ram_we high exactly one cycle; p0_rvalid pulses once with p0_rdata=0xA5C3 two cycles after the read gnt.
- Bank coverage, port 1: write 0x1111, 0x2222, 0x3333, 0x4444 to 0x0010, 0x1010, 0x2010, 0x3010, then read all -> each value returned from its own bank, no aliasing.
- Simultaneous reqs held for 4 transactions: both ports read -> grant order 0,1,0,1. Each rvalid appears only on the granted port; the other port's rdata is unchanged.
- Back-to-back contention with writes: p0 writes 0x3FFF=0xFFFF while p1 reads 0x3FFF -> p0 granted first. p1 then reads 0xFFFF. ram_data is never driven by the controller while ram_oe=1.

Source files
------------

// File: rtl/ram_large_arbiter.sv
// rtl/ram_large_arbiter.sv - two-port round-robin arbiter and access sequencer for the banked 16K x 16 RAM
module ram_large_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_gnt,
    output logic                  p0_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_gnt,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_DATA} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    port_q, port_d;
    logic                    last_grant_q, last_grant_d;
    logic                    p0_gnt_q, p0_gnt_d, p1_gnt_q, p1_gnt_d;
    logic                    p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
    logic [DATA_WIDTH-1:0]   p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

    // Arbitration, operand latching and the write/read access sequence
    always_comb begin
        logic win;
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        p0_gnt_d     = 1'b0;
        p1_gnt_d     = 1'b0;
        p0_rvalid_d  = 1'b0;
        p1_rvalid_d  = 1'b0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        win          = 1'b0;
        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    // Under contention the port that was not served last wins
                    win          = (p0_req && p1_req) ? ~last_grant_q : p1_req;
                    port_d       = win;
                    last_grant_d = win;
                    addr_d       = win ? p1_addr  : p0_addr;
                    wdata_d      = win ? p1_wdata : p0_wdata;
                    p0_gnt_d     = ~win;
                    p1_gnt_d     = win;
                    state_d      = (win ? p1_we : p0_we) ? WRITE : RD_ADDR;
                end
            end
            WRITE:   state_d = IDLE;
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                // RAM is driving the bus this cycle; capture for the owner
                if (port_q) begin
                    p1_rdata_d  = ram_data;
                    p1_rvalid_d = 1'b1;
                end else begin
                    p0_rdata_d  = ram_data;
                    p0_rvalid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched-operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            port_q       <= 1'b0;
            last_grant_q <= 1'b1;
            p0_gnt_q     <= 1'b0;
            p1_gnt_q     <= 1'b0;
            p0_rvalid_q  <= 1'b0;
            p1_rvalid_q  <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            p0_gnt_q     <= p0_gnt_d;
            p1_gnt_q     <= p1_gnt_d;
            p0_rvalid_q  <= p0_rvalid_d;
            p1_rvalid_q  <= p1_rvalid_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    // RAM strobes are pure state decodes; the bus is driven only while writing
    assign ram_cs    = (state_q != IDLE);
    assign ram_we    = (state_q == WRITE);
    assign ram_oe    = (state_q == RD_DATA);
    assign ram_addr  = addr_q;
    assign ram_data  = (state_q == WRITE) ? wdata_q : 'z;
    assign busy      = (state_q != IDLE);

    assign p0_gnt    = p0_gnt_q;
    assign p1_gnt    = p1_gnt_q;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_ram_large_arbiter.sv
// tb/tb_ram_large_arbiter.sv - directed self-checking bench for ram_large_arbiter
module tb_ram_large_arbiter;
    localparam int AW = 14;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] ram_addr;
    wire  [DW-1:0] ram_data;
    logic          ram_cs, ram_we, ram_oe, busy;

    int n_cmp = 0;
    int n_fail = 0;

    ram_large_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_cs(ram_cs),
        .ram_we(ram_we), .ram_oe(ram_oe), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM model: write or address capture on the edge, drive when oe
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_rd_q = '0;
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
        else if (ram_cs && !ram_oe) ram_rd_q <= mem[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_rd_q : 'z;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port == 0) begin p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; end
        else           begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; end
    endtask

    task automatic do_write(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d, output int ok);
        ok = 0;
        set_req(port, 1'b1, a, d);
        for (int i = 0; i < 20; i++) begin
            cyc();
            if ((port == 0) ? p0_gnt : p1_gnt) begin ok = 1; break; end
        end
        if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
        cyc();
    endtask

    task automatic do_read(input int port, input logic [AW-1:0] a, output logic [DW-1:0] data, output int lat);
        int got;
        got = 0;
        lat = -1;
        data = '0;
        set_req(port, 1'b0, a, '0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            if ((port == 0) ? p0_gnt : p1_gnt) begin got = 1; break; end
        end
        if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
        if (got == 1) begin
            for (int k = 1; k <= 5; k++) begin
                cyc();
                if ((port == 0) ? p0_rvalid : p1_rvalid) begin
                    lat = k;
                    data = (port == 0) ? p0_rdata : p1_rdata;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(); cyc();
        n_cmp++;
        if ({ram_cs, ram_we, ram_oe, busy, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b need 00000000", {ram_cs, ram_we, ram_oe, busy, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid});
        end
        n_cmp++;
        if (ram_addr !== 14'h0) begin n_fail++; $display("FAIL reset_addr got %h need 0000", ram_addr); end
        n_cmp++;
        if ({p0_rdata, p1_rdata} !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h need 0", {p0_rdata, p1_rdata}); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_write_read_p0();
        int wecnt, gcnt, lat, addr_bad;
        logic [DW-1:0] d;
        wecnt = 0; gcnt = 0; addr_bad = 0;
        set_req(0, 1'b1, 14'h0005, 16'hA5C3);
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (p0_gnt) begin gcnt++; p0_req = 1'b0; end
            if (ram_cs && ram_we) begin
                wecnt++;
                if (ram_addr !== 14'h0005 || ram_data !== 16'hA5C3) addr_bad++;
            end
        end
        p0_req = 1'b0;
        n_cmp++;
        if (wecnt !== 1) begin n_fail++; $display("FAIL wr_strobe_cycles got %0d need 1", wecnt); end
        n_cmp++;
        if (gcnt !== 1) begin n_fail++; $display("FAIL wr_gnt_count got %0d need 1", gcnt); end
        n_cmp++;
        if (addr_bad !== 0) begin n_fail++; $display("FAIL wr_addr_data got %0d bad cycles need 0", addr_bad); end
        do_read(0, 14'h0005, d, lat);
        n_cmp++;
        if (lat !== 2) begin n_fail++; $display("FAIL rd_latency got %0d need 2", lat); end
        n_cmp++;
        if (d !== 16'hA5C3) begin n_fail++; $display("FAIL rd_data_p0 got %h need a5c3", d); end
        cyc();
        n_cmp++;
        if (p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_single_pulse got %b need 0", p0_rvalid); end
    endtask

    task automatic test_reset_mid_read();
        int rv;
        rv = 0;
        set_req(0, 1'b0, 14'h0005, '0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (p0_gnt) break;
        end
        p0_req = 1'b0;
        cyc();
        n_cmp++;
        if (ram_oe !== 1'b1) begin n_fail++; $display("FAIL mid_read_in_rd_data got oe=%b need 1", ram_oe); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ram_cs, busy} !== 2'b00) begin n_fail++; $display("FAIL async_reset_cs_busy got %b need 00", {ram_cs, busy}); end
        n_cmp++;
        if (!($isunknown(ram_data) || ram_data === 16'h0)) begin
            n_fail++; $display("FAIL async_reset_bus got %h need released", ram_data);
        end
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (p0_rvalid || p1_rvalid) rv++;
        end
        n_cmp++;
        if (rv !== 0) begin n_fail++; $display("FAIL abandoned_rvalid got %0d need 0", rv); end
        n_cmp++;
        if (p0_rdata !== 16'h0) begin n_fail++; $display("FAIL abandoned_rdata got %h need 0000", p0_rdata); end
    endtask

    task automatic test_bank_coverage_p1();
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] vals [4];
        logic [DW-1:0] d;
        int ok, lat;
        addrs = '{14'h0010, 14'h1010, 14'h2010, 14'h3010};
        vals  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        for (int i = 0; i < 4; i++) begin
            do_write(1, addrs[i], vals[i], ok);
            n_cmp++;
            if (ok !== 1) begin n_fail++; $display("FAIL bank_wr_gnt[%0d] got %0d need 1", i, ok); end
        end
        for (int i = 0; i < 4; i++) begin
            do_read(1, addrs[i], d, lat);
            n_cmp++;
            if (d !== vals[i] || lat !== 2) begin
                n_fail++; $display("FAIL bank_rd[%0d] got %h lat %0d need %h lat 2", i, d, lat, vals[i]);
            end
        end
        n_cmp++;
        if (p0_rdata !== 16'h0) begin n_fail++; $display("FAIL bank_p0_untouched got %h need 0000", p0_rdata); end
    endtask

    task automatic test_contention();
        logic [3:0] order;
        logic [DW-1:0] p1_prev;
        int ng, r0, r1, both;
        order = '0; ng = 0; r0 = 0; r1 = 0; both = 0;
        p1_prev = 16'h4444;
        set_req(0, 1'b0, 14'h0010, '0);
        set_req(1, 1'b0, 14'h1010, '0);
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (p0_gnt && p1_gnt) both++;
            if (p0_gnt && ng < 4) begin order[ng] = 1'b0; ng++; end
            if (p1_gnt && ng < 4) begin order[ng] = 1'b1; ng++; end
            if (ng == 4) begin p0_req = 1'b0; p1_req = 1'b0; end
            if (p0_rvalid) begin
                r0++;
                n_cmp++;
                if (p0_rdata !== 16'h1111 || p1_rdata !== p1_prev) begin
                    n_fail++; $display("FAIL cont_p0_rv got %h/%h need 1111/%h", p0_rdata, p1_rdata, p1_prev);
                end
            end
            if (p1_rvalid) begin
                r1++;
                n_cmp++;
                if (p1_rdata !== 16'h2222 || p0_rdata !== 16'h1111) begin
                    n_fail++; $display("FAIL cont_p1_rv got %h/%h need 2222/1111", p1_rdata, p0_rdata);
                end
                p1_prev = 16'h2222;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        n_cmp++;
        if (ng !== 4 || order !== 4'b1010) begin n_fail++; $display("FAIL grant_order got n=%0d bits=%b need n=4 bits=1010", ng, order); end
        n_cmp++;
        if (r0 !== 2 || r1 !== 2 || both !== 0) begin
            n_fail++; $display("FAIL cont_rvalid_counts got r0=%0d r1=%0d both=%0d need 2 2 0", r0, r1, both);
        end
    endtask

    task automatic test_back_to_back();
        int first, bad, p0rv, got1;
        logic [DW-1:0] d;
        first = -1; bad = 0; p0rv = 0; got1 = 0; d = '0;
        set_req(0, 1'b1, 14'h3FFF, 16'hFFFF);
        set_req(1, 1'b0, 14'h3FFF, 16'h5A5A);
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (p0_gnt) begin if (first < 0) first = 0; p0_req = 1'b0; end
            if (p1_gnt) begin if (first < 0) first = 1; p1_req = 1'b0; end
            if (ram_oe && ram_we) bad++;
            if (ram_cs && !ram_we && !ram_oe && !($isunknown(ram_data) || ram_data === 16'h0)) bad++;
            if (p0_rvalid) p0rv++;
            if (p1_rvalid) begin got1++; d = p1_rdata; end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        n_cmp++;
        if (first !== 0) begin n_fail++; $display("FAIL b2b_first_grant got %0d need 0", first); end
        n_cmp++;
        if (got1 !== 1 || d !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_read got %h x%0d need ffff x1", d, got1); end
        n_cmp++;
        if (bad !== 0 || p0rv !== 0) begin n_fail++; $display("FAIL b2b_bus got bad=%0d p0rv=%0d need 0 0", bad, p0rv); end
    endtask

    initial begin
        test_reset();
        test_write_read_p0();
        test_reset_mid_read();
        test_bank_coverage_p1();
        test_contention();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout got running need finished");
        $fatal(1, "timeout");
    end
endmodule
